// File: rtl/meter_pkg.sv
// meter_pkg: shared widths, engine state enum, default constants and the BCD nibble-adjust helper
package meter_pkg;
  localparam int COUNT_W = 14;
  localparam int BCD_W = 16;
  localparam int ITERS = COUNT_W;
  localparam int DEF_MAX_COUNT = 9999;
  localparam int DEF_LOW_THRESH = 180;
  localparam int DEF_PRESET1 = 15;
  localparam int DEF_PRESET2 = 150;
  localparam int DEF_ADD1 = 60;
  localparam int DEF_ADD2 = 120;
  localparam int DEF_ADD3 = 180;
  localparam int DEF_ADD4 = 300;
  typedef enum logic [1:0] {LOAD, SHIFT, DONE} bcd_state_t;
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < BCD_W / 4; i++)
      r[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/meter_control_if.sv
// meter_control_if: button/tick pulses in, BCD digits, blink request and count out
interface meter_control_if;
  import meter_pkg::*;
  logic tick_1hz;
  logic add1, add2, add3, add4;
  logic rst1, rst2;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic state_blink;
  logic [COUNT_W-1:0] count;
  modport master (
    output tick_1hz, add1, add2, add3, add4, rst1, rst2,
    input digit3, digit2, digit1, digit0, state_blink, count
  );
  modport slave (
    input tick_1hz, add1, add2, add3, add4, rst1, rst2,
    output digit3, digit2, digit1, digit0, state_blink, count
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter; ports clk, rst, start, bin in; bcd (held between conversions), done out
module bin2bcd_seq
  import meter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               done
);
  bcd_state_t state_q, state_d;
  logic [3:0] iter_q, iter_d;
  logic [BCD_W+COUNT_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      iter_q <= '0;
      sr_q <= '0;
      bcd_q <= '0;
    end else begin
      state_q <= state_d;
      iter_q <= iter_d;
      sr_q <= sr_d;
      bcd_q <= bcd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    iter_d = iter_q;
    sr_d = sr_q;
    bcd_d = bcd_q;
    if (state_q == LOAD) begin
      sr_d = {{BCD_W{1'b0}}, bin};
      iter_d = '0;
      state_d = start ? SHIFT : LOAD;
    end else if (state_q == SHIFT) begin
      sr_d = {dabble(sr_q[BCD_W+COUNT_W-1:COUNT_W]), sr_q[COUNT_W-1:0]} << 1;
      iter_d = iter_q + 4'd1;
      state_d = iter_q == 4'(ITERS - 1) ? DONE : SHIFT;
    end else begin
      bcd_d = sr_q[BCD_W+COUNT_W-1:COUNT_W];
      state_d = LOAD;
    end
  end
  assign bcd = bcd_q;
  assign done = state_q == DONE;
endmodule

// File: rtl/meter_control.sv
// meter_control: saturating parking-time counter with presets, adds, 1 Hz decrement, blink request and BCD digits
module meter_control
  import meter_pkg::*;
#(
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int LOW_THRESH = DEF_LOW_THRESH,
  parameter int PRESET1 = DEF_PRESET1,
  parameter int PRESET2 = DEF_PRESET2,
  parameter int ADD1 = DEF_ADD1,
  parameter int ADD2 = DEF_ADD2,
  parameter int ADD3 = DEF_ADD3,
  parameter int ADD4 = DEF_ADD4
) (
  input logic clk,
  input logic rst,
  meter_control_if.slave bus
);
  localparam logic [COUNT_W:0] MAX_W = (COUNT_W+1)'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] LOW_W = COUNT_W'(LOW_THRESH);
  logic [COUNT_W-1:0] count_q, next;
  logic [COUNT_W:0] addval, dec, sum;
  logic blink_q;
  logic [BCD_W-1:0] bcd;
  logic done;
  always_comb begin
    addval = bus.add4 ? (COUNT_W+1)'(ADD4) :
             bus.add3 ? (COUNT_W+1)'(ADD3) :
             bus.add2 ? (COUNT_W+1)'(ADD2) :
             bus.add1 ? (COUNT_W+1)'(ADD1) : '0;
    dec = {{COUNT_W{1'b0}}, bus.tick_1hz && count_q != '0};
    sum = {1'b0, count_q} - dec + addval;
    next = bus.rst1 ? COUNT_W'(PRESET1) :
           bus.rst2 ? COUNT_W'(PRESET2) :
           sum > MAX_W ? MAX_W[COUNT_W-1:0] : sum[COUNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      blink_q <= 1'b1;
    end else begin
      count_q <= next;
      blink_q <= next < LOW_W;
    end
  end
  bin2bcd_seq u_bcd (
    .clk(clk),
    .rst(rst),
    .start(1'b1),
    .bin(count_q),
    .bcd(bcd),
    .done(done)
  );
  assign bus.count = count_q;
  assign bus.state_blink = blink_q;
  assign {bus.digit3, bus.digit2, bus.digit1, bus.digit0} = bcd;
endmodule

// File: tb/tb_meter_control.sv
// tb_meter_control: table vectors, directed corner sequences and random stimulus against a reference model
module tb_meter_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int mdl = 0;
  meter_control_if bus ();
  meter_control dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] in;
    int exp_count;
    logic exp_blink;
  } vec_t;
  vec_t tbl[12];

  function automatic int model_next(int c, logic [6:0] in);
    int addv, v;
    if (in[6]) return 15;
    if (in[5]) return 150;
    addv = in[4] ? 300 : in[3] ? 180 : in[2] ? 120 : in[1] ? 60 : 0;
    v = c + addv - ((in[0] && c > 0) ? 1 : 0);
    return v > 9999 ? 9999 : v;
  endfunction

  function automatic int bcd_of(int c);
    return ((c / 1000) << 12) | (((c / 100) % 10) << 8) | (((c / 10) % 10) << 4) | (c % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {bus.rst1, bus.rst2, bus.add4, bus.add3, bus.add2, bus.add1, bus.tick_1hz} = in;
  endtask

  task automatic pulse(input logic [6:0] in);
    drive(in);
    mdl = model_next(mdl, in);
    @(posedge clk); #1;
    drive(7'd0);
  endtask

  task automatic pulse_chk(input string name, input logic [6:0] in);
    pulse(in);
    chk({name, "_count"}, int'(bus.count), mdl);
    chk({name, "_blink"}, int'(bus.state_blink), int'(mdl < 180));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_digits(input string name);
    chk(name, int'({bus.digit3, bus.digit2, bus.digit1, bus.digit0}), bcd_of(mdl));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(7'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mdl = 0;
  endtask

  initial begin
    bit stale;
    logic [6:0] r;
    tbl[0]  = '{7'b0000001, 0, 1'b1};
    tbl[1]  = '{7'b0010000, 300, 1'b0};
    tbl[2]  = '{7'b0000001, 299, 1'b0};
    tbl[3]  = '{7'b0100000, 150, 1'b1};
    tbl[4]  = '{7'b0000011, 209, 1'b0};
    tbl[5]  = '{7'b0010100, 509, 1'b0};
    tbl[6]  = '{7'b1110000, 15, 1'b1};
    tbl[7]  = '{7'b0000001, 14, 1'b1};
    tbl[8]  = '{7'b0001000, 194, 1'b0};
    tbl[9]  = '{7'b0000010, 254, 1'b0};
    tbl[10] = '{7'b0100001, 150, 1'b1};
    tbl[11] = '{7'b0000100, 270, 1'b0};
    drive(7'd0);
    idle(2);
    do_reset();
    chk("reset_count", int'(bus.count), 0);
    chk("reset_blink", int'(bus.state_blink), 1);
    chk_digits("reset_digits");
    idle(40);
    chk("idle_count", int'(bus.count), 0);
    chk_digits("idle_digits");
    for (int i = 0; i < 12; i++) begin
      pulse(tbl[i].in);
      chk($sformatf("tbl%0d_count", i), int'(bus.count), tbl[i].exp_count);
      chk($sformatf("tbl%0d_blink", i), int'(bus.state_blink), int'(tbl[i].exp_blink));
    end
    idle(34);
    chk_digits("tbl_digits");
    do_reset();
    pulse_chk("add4", 7'b0010000);
    idle(40);
    chk_digits("d300");
    for (int i = 0; i < 121; i++) begin
      pulse(7'b0000001);
      chk("tick_blink", int'(bus.state_blink), int'(mdl < 180));
    end
    chk("tick_count", int'(bus.count), 179);
    chk("tick_blink179", int'(bus.state_blink), 1);
    pulse_chk("rst2", 7'b0100000);
    pulse_chk("add1_tick", 7'b0000011);
    chk("add1_tick_209", int'(bus.count), 209);
    pulse_chk("add2_add4", 7'b0010100);
    chk("add2_add4_509", int'(bus.count), 509);
    do_reset();
    for (int i = 0; i < 33; i++) pulse(7'b0010000);
    chk("to9900", int'(bus.count), 9900);
    pulse_chk("sat1", 7'b0010000);
    chk("sat1_9999", int'(bus.count), 9999);
    pulse_chk("sat2", 7'b0010000);
    chk("sat2_9999", int'(bus.count), 9999);
    pulse_chk("sat_tick_add", 7'b0000011);
    pulse_chk("sat3", 7'b0010000);
    idle(40);
    chk_digits("d9999");
    pulse_chk("rst1", 7'b1000000);
    for (int i = 1; i <= 20; i++) begin
      pulse(7'b0000001);
      chk($sformatf("down%0d", i), int'(bus.count), i >= 15 ? 0 : 15 - i);
    end
    pulse_chk("rst1_rst2", 7'b1100000);
    chk("rst1_rst2_15", int'(bus.count), 15);
    do_reset();
    pulse(7'b0010000);
    idle(40);
    chk_digits("pre_abort");
    stale = 1'b0;
    pulse(7'b0000010);
    for (int i = 0; i < 4; i++) begin
      if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} == 16'h0360) stale = 1'b1;
      idle(1);
    end
    do_reset();
    chk("abort_count", int'(bus.count), 0);
    chk_digits("abort_digits");
    for (int i = 0; i < 40; i++) begin
      if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} == 16'h0360) stale = 1'b1;
      idle(1);
    end
    chk("abort_no_stale", int'(stale), 0);
    chk_digits("abort_digits_late");
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = 7'($urandom);
      r[6] = ($urandom_range(0, 40) == 0);
      r[5] = ($urandom_range(0, 40) == 0);
      for (int b = 1; b < 5; b++) r[b] = r[b] && ($urandom_range(0, 5) == 0);
      pulse_chk("rnd", r);
      if (i % 50 == 49) begin
        idle(34);
        chk_digits("rnd_digits");
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
